// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch PC generator and its branch target buffer.
package pc_gen_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'd0;
    localparam cnt_t CNT_WNT = 2'd1;
    localparam cnt_t CNT_WT  = 2'd2;
    localparam cnt_t CNT_ST  = 2'd3;

    // Saturating 2-bit direction counter step.
    function automatic cnt_t cnt_train(input cnt_t c, input logic taken);
        cnt_t n;
        n = c;
        if (taken) begin
            if (c != CNT_ST) n = c + 2'd1;
            else             n = c;
        end else begin
            if (c != CNT_SNT) n = c - 2'd1;
            else              n = c;
        end
        return n;
    endfunction

    function automatic logic cnt_predicts_taken(input cnt_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped BTB: combinational lookup of pre-update contents, registered training port.
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 16,
    parameter int INST_BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_lk_pc,
    output logic              o_lk_taken,
    output logic [ADDR_W-1:0] o_lk_target,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int OFF_W = $clog2(INST_BYTES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      r_target [BTB_ENTRIES];
    cnt_t                   r_cnt    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_lk_hit;
    logic             w_upd_hit;
    logic             w_unused_offset;

    assign w_lk_idx  = i_lk_pc[OFF_W+IDX_W-1:OFF_W];
    assign w_lk_tag  = i_lk_pc[ADDR_W-1:OFF_W+IDX_W];
    assign w_upd_idx = i_upd_pc[OFF_W+IDX_W-1:OFF_W];
    assign w_upd_tag = i_upd_pc[ADDR_W-1:OFF_W+IDX_W];

    // Byte-offset bits never select an entry.
    assign w_unused_offset = |((i_lk_pc | i_upd_pc) & ADDR_W'(INST_BYTES - 1));

    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign o_lk_taken  = w_lk_hit && cnt_predicts_taken(r_cnt[w_lk_idx]);
    assign o_lk_target = r_target[w_lk_idx];

    // Training and clear; tags/targets are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (rst) begin
                r_valid <= '0;
                for (int i = 0; i < BTB_ENTRIES; i++) begin
                    r_cnt[i] <= CNT_WNT;
                end
            end else if (i_upd_valid) begin
                if (w_upd_hit) begin
                    r_cnt[w_upd_idx] <= cnt_train(r_cnt[w_upd_idx], i_upd_taken);
                    if (i_upd_taken) begin
                        r_target[w_upd_idx] <= i_upd_target;
                    end
                end else if (i_upd_taken) begin
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= i_upd_target;
                    r_cnt[w_upd_idx]    <= CNT_WT;
                end
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with next-PC priority mux (reset > redirect > predicted/sequential > hold).
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INST_BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rdy,
    input  logic              i_stall,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_ex_redirect,
    input  logic [ADDR_W-1:0] i_ex_redirect_pc,
    input  logic              i_ex_upd_valid,
    input  logic [ADDR_W-1:0] i_ex_upd_pc,
    input  logic              i_ex_upd_taken,
    input  logic [ADDR_W-1:0] i_ex_upd_target
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_btb_target;
    logic              w_btb_taken;

    pc_gen_btb #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES),
        .INST_BYTES  (INST_BYTES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_rdy),
        .i_lk_pc      (r_pc),
        .o_lk_taken   (w_btb_taken),
        .o_lk_target  (w_btb_target),
        .i_upd_valid  (i_ex_upd_valid),
        .i_upd_pc     (i_ex_upd_pc),
        .i_upd_taken  (i_ex_upd_taken),
        .i_upd_target (i_ex_upd_target)
    );

    // Sequential increment wraps naturally at ADDR_W bits.
    assign w_seq_pc      = r_pc + ADDR_W'(INST_BYTES);
    assign o_pred_taken  = w_btb_taken;
    assign o_pred_target = w_btb_taken ? w_btb_target : w_seq_pc;
    assign o_pc          = r_pc;

    // PC register; rdy low freezes everything including reset.
    always_ff @(posedge clk) begin
        if (i_rdy) begin
            if (rst) begin
                r_pc <= RESET_PC;
            end else if (i_ex_redirect) begin
                r_pc <= i_ex_redirect_pc;
            end else if (!i_stall) begin
                r_pc <= o_pred_target;
            end else begin
                r_pc <= r_pc;
            end
        end
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the head of the pipeline, in front of the instruction fetch stage. Each cycle it holds the current fetch PC and predicts the next one, either sequential or a predicted-taken target. It accepts redirects and training updates from EX, and honours the fetch stall and the global `rdy`.

## Interface
- `ADDR_W`, 32: PC / target width.
- `BTB_ENTRIES`, 16: BTB depth; power of two, ≥2.
- `RESET_PC`, 0: PC loaded on reset.
- `INST_BYTES`, 4: sequential increment; power of two.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rdy`  in  1  global enable; low freezes all state.
- `stall`  in  1  fetch stall; holds PC.
- `pc`  out  ADDR_W  current fetch PC (registered).
- `pred_taken`  out  1  prediction for `pc` (combinational from state).
- `pred_target`  out  ADDR_W  predicted next PC for `pc`.
- `ex_redirect`  in  1  EX mispredict; load `ex_redirect_pc`.
- `ex_redirect_pc`  in  ADDR_W  correct next PC.
- `ex_upd_valid`  in  1  a resolved branch trains the BTB.
- `ex_upd_pc`  in  ADDR_W  PC of the resolved branch.
- `ex_upd_taken`  in  1  actual direction.
- `ex_upd_target`  in  ADDR_W  actual taken target.

## Operation
- Index: `IDX_W = log2(BTB_ENTRIES)`. `OFF_W = log2(INST_BYTES)`. Index = `pc[OFF_W+IDX_W-1:OFF_W]`. Tag = `pc[ADDR_W-1:OFF_W+IDX_W]`.
- Each entry holds a valid bit, a tag, a target and a 2-bit counter (0 = strong NT, 1 = weak NT, 2 = weak T, 3 = strong T).
- Lookup: hit = valid && tag match. `pred_taken` = hit && counter[1]. `pred_target` = `pred_taken ? target : pc + INST_BYTES`. The addition wraps modulo 2^ADDR_W.
- PC update priority, evaluated only when `rdy`=1:
  1. `rst`
  2. `ex_redirect` (overrides `stall`)
  3. `!stall`: load `pred_target`
  4. otherwise hold.
- Training when `ex_upd_valid` && `rdy`:
  - On a hit to the addressed entry: the counter saturates up if taken, down if not taken. The target is rewritten when taken.
  - On a miss with taken: allocate the entry. Set valid, write the tag and target, and set the counter to 2.
  - On a miss with not taken: no change (no allocation).
- Lookup reads pre-update state. When an update and a lookup hit the same entry in the same cycle, the lookup sees the old contents and the new contents are visible next cycle.
- `ex_redirect` and `ex_upd_valid` may be asserted together; both take effect.

## Timing
- Reset values:
  - `pc` = `RESET_PC`.
  - All valid bits = 0 and all counters = 1. Targets and tags are don't-care.
  - Consequently `pred_taken` = 0 and `pred_target` = `RESET_PC + INST_BYTES` in the first cycle after reset.
- `rst` asserted mid-operation wins over redirect, update and stall in the same cycle.
- `pc` changes one cycle after the qualifying edge. Redirect latency is 1 cycle.
- Prediction has zero-cycle latency relative to `pc`.
- `rdy`=0: `pc`, the BTB and the counters all hold. Updates and redirects presented while `rdy`=0 are lost; the upstream must hold them.
- `stall`=1 without a redirect: `pc` holds. BTB training still proceeds.

## Structure
- Shared address-width constants (`InstAddrBus`, `ZERO_WORD`) come from `consts.vh`. Add `BtbIdxBus` and `BtbCntBus` there.
- Sub-module `btb` holds the storage arrays, the combinational lookup port and the registered update port with counter logic.
- `pc_gen` keeps the PC register and the next-PC priority mux.

## Test plan
- Reset, then `stall`=0 for 4 cycles: `pc` = 0, 4, 8, 12; `pred_taken`=0 throughout.
- Train `ex_upd_pc`=0x10, taken, target 0x40. Re-fetch 0x10: `pred_taken`=1, next `pc`=0x40.
- Train 0x10 not-taken twice: counter goes 2→1→0. Fetch 0x10: `pred_taken`=0, next `pc`=0x14.
- `stall`=1 with `ex_redirect`=1 and `ex_redirect_pc`=0x100: next `pc`=0x100. Same stimulus with `rdy`=0: `pc` holds.
- Aliasing with `BTB_ENTRIES`=16: train 0x10 taken to 0x40, then fetch 0x50. Same index, different tag, so `pred_taken`=0 and next `pc`=0x54.
- Wrap-around: `pc`=0xFFFFFFFC with no hit, so next `pc`=0x0. Assert `rst` while stalled with a redirect pending: `pc`=`RESET_PC` and the BTB is cleared.
